// File: rtl/cntr_n.sv
// Up/down counter with step 1 or 2, parallel load and wrap or saturate behaviour.
// Control is registered into a Moore state first; the counter applies that state's action on the following edge.
module cntr_n #(
  parameter int WIDTH = 8,
  parameter int SAT   = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             en,
  input  logic             inc,
  input  logic             step2,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] d_out,
  output logic [2:0]       o_state,
  output logic             tc_up,
  output logic             tc_dn,
  output logic             ovf
);

  localparam logic [2:0] ST_IDLE = 3'b000;
  localparam logic [2:0] ST_LOAD = 3'b001;
  localparam logic [2:0] ST_INC  = 3'b010;
  localparam logic [2:0] ST_INC2 = 3'b011;
  localparam logic [2:0] ST_DEC  = 3'b100;
  localparam logic [2:0] ST_DEC2 = 3'b101;

  localparam logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}};

  logic [2:0]       state;
  logic [2:0]       next_state;
  logic [WIDTH-1:0] load_reg;
  logic [WIDTH-1:0] next_cnt;
  logic             range_err;
  logic [WIDTH:0]   ext_cnt;
  logic [WIDTH:0]   step_val;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic             is_two;

  // Unused encodings fall back to IDLE regardless of the inputs.
  always_comb begin
    next_state = ST_IDLE;
    if (state <= ST_DEC2) begin
      if (load)
        next_state = ST_LOAD;
      else if (!en)
        next_state = ST_IDLE;
      else if (inc)
        next_state = step2 ? ST_INC2 : ST_INC;
      else
        next_state = step2 ? ST_DEC2 : ST_DEC;
    end
  end

  assign ext_cnt  = {1'b0, d_out};
  assign is_two   = (state == ST_INC2) || (state == ST_DEC2);
  assign step_val = {{(WIDTH-1){1'b0}}, is_two, ~is_two};
  assign sum      = ext_cnt + step_val;
  assign diff     = ext_cnt - step_val;

  // The extra top bit of sum/diff flags a result outside 0..max.
  always_comb begin
    next_cnt  = d_out;
    range_err = 1'b0;
    case (state)
      ST_LOAD: next_cnt = load_reg;
      ST_INC, ST_INC2: begin
        range_err = sum[WIDTH];
        next_cnt  = (sum[WIDTH] && (SAT != 0)) ? MAX_VAL : sum[WIDTH-1:0];
      end
      ST_DEC, ST_DEC2: begin
        range_err = diff[WIDTH];
        next_cnt  = (diff[WIDTH] && (SAT != 0)) ? '0 : diff[WIDTH-1:0];
      end
      default: next_cnt = d_out;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      load_reg <= '0;
      d_out    <= '0;
      ovf      <= 1'b0;
    end else begin
      state <= next_state;
      if (next_state == ST_LOAD)
        load_reg <= d_in;
      d_out <= next_cnt;
      ovf   <= range_err;
    end
  end

  assign o_state = state;
  assign tc_up   = (d_out == MAX_VAL);
  assign tc_dn   = (d_out == '0);

endmodule

// File: tb/tb_cntr_n.sv
// Self-checking bench for cntr_n: a wrapping and a saturating instance share stimulus and are
// checked every cycle against an integer model, plus directed literal expectations.
module tb_cntr_n;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       load = 1'b0;
  logic       en = 1'b0;
  logic       inc = 1'b0;
  logic       step2 = 1'b0;
  logic [7:0] d_in = 8'h00;

  logic [7:0] d_out0, d_out1;
  logic [2:0] o_state0, o_state1;
  logic       tc_up0, tc_up1, tc_dn0, tc_dn1, ovf0, ovf1;

  int checks = 0;
  int failures = 0;
  bit model_on = 1'b0;

  // Model: pending action (spec state number), load value, per-instance count and ovf.
  int m_state = 0;
  int m_ld = 0;
  int m_c0 = 0;
  int m_c1 = 0;
  bit m_o0 = 1'b0;
  bit m_o1 = 1'b0;
  int delta, v;

  cntr_n #(.WIDTH(8), .SAT(0)) dut_wrap (
    .clk(clk), .reset_n(reset_n), .load(load), .en(en), .inc(inc), .step2(step2),
    .d_in(d_in), .d_out(d_out0), .o_state(o_state0), .tc_up(tc_up0), .tc_dn(tc_dn0), .ovf(ovf0)
  );

  cntr_n #(.WIDTH(8), .SAT(1)) dut_sat (
    .clk(clk), .reset_n(reset_n), .load(load), .en(en), .inc(inc), .step2(step2),
    .d_in(d_in), .d_out(d_out1), .o_state(o_state1), .tc_up(tc_up1), .tc_dn(tc_dn1), .ovf(ovf1)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_state = 0; m_ld = 0; m_c0 = 0; m_c1 = 0; m_o0 = 1'b0; m_o1 = 1'b0;
    end else begin
      case (m_state)
        2: delta = 1;
        3: delta = 2;
        4: delta = -1;
        5: delta = -2;
        default: delta = 0;
      endcase
      if (m_state == 1) begin
        m_c0 = m_ld; m_c1 = m_ld; m_o0 = 1'b0; m_o1 = 1'b0;
      end else begin
        v = m_c0 + delta;
        m_o0 = (v < 0) || (v > 255);
        m_c0 = (v + 256) % 256;
        v = m_c1 + delta;
        m_o1 = (v < 0) || (v > 255);
        m_c1 = (v < 0) ? 0 : ((v > 255) ? 255 : v);
      end
      m_state = load ? 1 : (!en ? 0 : (inc ? (step2 ? 3 : 2) : (step2 ? 5 : 4)));
      if (load) m_ld = int'(d_in);
    end
  end

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (model_on) begin
      check_output("model_d_out_wrap", int'(d_out0), m_c0);
      check_output("model_d_out_sat", int'(d_out1), m_c1);
      check_output("model_state_wrap", int'(o_state0), m_state);
      check_output("model_state_sat", int'(o_state1), m_state);
      check_output("model_ovf_wrap", int'(ovf0), int'(m_o0));
      check_output("model_ovf_sat", int'(ovf1), int'(m_o1));
      check_output("model_tc_up_wrap", int'(tc_up0), int'(m_c0 == 255));
      check_output("model_tc_dn_wrap", int'(tc_dn0), int'(m_c0 == 0));
      check_output("model_tc_up_sat", int'(tc_up1), int'(m_c1 == 255));
      check_output("model_tc_dn_sat", int'(tc_dn1), int'(m_c1 == 0));
    end
  end

  task automatic apply_stimulus(input logic ld, input logic e, input logic i, input logic s2,
                                input logic [7:0] d);
    load = ld; en = e; inc = i; step2 = s2; d_in = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_value(input logic [7:0] d);
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, d);
    tick();
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    tick();
  endtask

  typedef struct { logic [7:0] start; logic up; logic two; } vec_t;
  vec_t vecs[6];

  initial begin
    vecs[0] = '{8'hFF, 1'b1, 1'b0};
    vecs[1] = '{8'hFF, 1'b1, 1'b1};
    vecs[2] = '{8'h00, 1'b0, 1'b0};
    vecs[3] = '{8'h00, 1'b0, 1'b1};
    vecs[4] = '{8'h7F, 1'b1, 1'b1};
    vecs[5] = '{8'h02, 1'b0, 1'b1};

    #1 model_on = 1'b1;
    #11;
    check_output("reset_d_out", int'(d_out0), 0);
    check_output("reset_state", int'(o_state0), 0);
    check_output("reset_tc_dn", int'(tc_dn0), 1);
    check_output("reset_tc_up", int'(tc_up0), 0);
    reset_n = 1'b1;
    tick();
    check_output("post_reset_tc_dn", int'(tc_dn1), 1);

    // Load 5A: state LOAD after edge 1, value after edge 2.
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h5A);
    tick();
    check_output("load_state_e1", int'(o_state0), 1);
    check_output("load_dout_e1", int'(d_out0), 0);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    tick();
    check_output("load_dout_e2", int'(d_out0), 8'h5A);
    check_output("load_ovf_e2", int'(ovf0), 0);

    // Wrap up FE + 2.
    load_value(8'hFE);
    apply_stimulus(1'b0, 1'b1, 1'b1, 1'b1, 8'h00);
    tick();
    check_output("wrapup_state", int'(o_state0), 3);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    tick();
    check_output("wrapup_dout", int'(d_out0), 8'h00);
    check_output("wrapup_ovf", int'(ovf0), 1);
    check_output("wrapup_tc_dn", int'(tc_dn0), 1);
    check_output("satup_dout", int'(d_out1), 8'hFF);
    check_output("satup_tc_up", int'(tc_up1), 1);
    tick();
    check_output("wrapup_ovf_clear", int'(ovf0), 0);

    // Saturate down 01 - 2, twice.
    load_value(8'h01);
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
    tick();
    tick();
    check_output("satdn_dout_1", int'(d_out1), 8'h00);
    check_output("satdn_ovf_1", int'(ovf1), 1);
    check_output("wrapdn_dout_1", int'(d_out0), 8'hFF);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    tick();
    check_output("satdn_dout_2", int'(d_out1), 8'h00);
    check_output("satdn_ovf_2", int'(ovf1), 1);
    check_output("wrapdn_dout_2", int'(d_out0), 8'hFD);
    tick();
    check_output("satdn_ovf_idle", int'(ovf1), 0);

    // Load wins over count in the same cycle.
    apply_stimulus(1'b1, 1'b1, 1'b1, 1'b0, 8'h10);
    tick();
    check_output("prio_state", int'(o_state0), 1);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    tick();
    check_output("prio_dout", int'(d_out0), 8'h10);

    // Async reset mid-count at 37.
    load_value(8'h37);
    apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
    tick();
    check_output("midcnt_dout", int'(d_out0), 8'h37);
    #2 reset_n = 1'b0;
    #1;
    check_output("areset_dout", int'(d_out0), 0);
    check_output("areset_state", int'(o_state0), 0);
    check_output("areset_ovf", int'(ovf0), 0);
    #2 reset_n = 1'b1;
    tick();
    check_output("rel_dout", int'(d_out0), 0);
    check_output("rel_state", int'(o_state0), 2);
    tick();
    check_output("rel_count", int'(d_out0), 1);

    // Idle hold at 80 for 10 cycles.
    load_value(8'h80);
    for (int k = 0; k < 10; k++) begin
      tick();
      check_output("idle_dout", int'(d_out0), 8'h80);
      check_output("idle_state", int'(o_state0), 0);
    end

    // Boundary vectors for both modes, checked by the model.
    for (int k = 0; k < 6; k++) begin
      load_value(vecs[k].start);
      apply_stimulus(1'b0, 1'b1, vecs[k].up, vecs[k].two, 8'h00);
      tick();
      tick();
      apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      tick();
      tick();
    end

    // Back-to-back loads with changing data: last sampled value wins.
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h11);
    tick();
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h22);
    tick();
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    tick();
    check_output("reload_dout", int'(d_out0), 8'h22);
    tick();

    model_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
